// File: rtl/prime_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// prime_sweep_ctrl
//
// Purpose
//   Sequencer for a purely combinational prime detector. An accepted start
//   walks a candidate over [lo..hi]. The candidate is driven out on o_cand, and
//   i_is_prime is sampled in the same cycle. Every prime that is found goes out
//   on a valid/ready stream. A running prime count is kept for the current or
//   last sweep.
//
// Optional feature
//   PRIME_SWEEP_MAP_EN : when defined, adds o_prime_map. Bit[cand] is set for
//                        each prime found. The map is cleared on an accepted
//                        start and held through DONE. When the macro is
//                        undefined, the port and the register are absent.
//
// Ports
//   i_clk          in   1          single clock, rising edge
//   i_rst          in   1          synchronous, active-high reset
//   i_start        in   1          begin sweep; sampled only in IDLE or DONE
//   i_lo           in   WIDTH      first candidate, latched on accepted start
//   i_hi           in   WIDTH      last candidate (inclusive), latched on start
//   o_cand         out  WIDTH      candidate driven to the detector input
//   i_is_prime     in   1          detector result for o_cand, same cycle
//   o_prime_valid  out  1          o_prime_data holds a prime
//   o_prime_data   out  WIDTH      prime value
//   i_prime_ready  in   1          consumer accepts when valid && ready
//   o_busy         out  1          high in SCAN or EMIT
//   o_done         out  1          level; high in DONE until next accepted start
//   o_prime_count  out  CNT_W      primes found in the current/last sweep
//   o_prime_map    out  2**WIDTH   only with PRIME_SWEEP_MAP_EN
//   o_state        out  2          debug view of the FSM state
//
// Handshake: a transfer happens on the rising edge where o_prime_valid and
// i_prime_ready are both high. Once o_prime_valid is raised, it and
// o_prime_data stay unchanged until that transfer. Valid never depends on ready.
// Reset is the only exception: it drops valid without a transfer.
// -----------------------------------------------------------------------------
module prime_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_lo,
    input  logic [WIDTH-1:0]      i_hi,
    output logic [WIDTH-1:0]      o_cand,
    input  logic                  i_is_prime,
    output logic                  o_prime_valid,
    output logic [WIDTH-1:0]      o_prime_data,
    input  logic                  i_prime_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_prime_count,
`ifdef PRIME_SWEEP_MAP_EN
    output logic [(2**WIDTH)-1:0] o_prime_map,
`endif
    output logic [1:0]            o_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_hi;
    logic             r_prime_valid;
    logic [WIDTH-1:0] r_prime_data;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_count;
    logic             w_last;
    logic             w_xfer;
    logic             w_count_max;
`ifdef PRIME_SWEEP_MAP_EN
    logic [(2**WIDTH)-1:0] r_map;
`endif

    // The sweep ends by comparing against hi before any increment. A sweep
    // that ends at the top of the range therefore never wraps cand back to 0.
    assign w_last      = (r_cand == r_hi);
    assign w_xfer      = r_prime_valid && i_prime_ready;
    assign w_count_max = (r_count == {CNT_W{1'b1}});

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_next_state = (i_lo <= i_hi) ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                if (i_is_prime) begin
                    w_next_state = S_EMIT;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_EMIT: begin
                if (w_xfer) begin
                    w_next_state = w_last ? S_DONE : S_SCAN;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cand        <= '0;
            r_hi          <= '0;
            r_prime_valid <= 1'b0;
            r_prime_data  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_count       <= '0;
`ifdef PRIME_SWEEP_MAP_EN
            r_map         <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            // busy and done are registered decodes of the next state, so they
            // switch on the same edge as the state.
            r_busy  <= (w_next_state == S_SCAN) || (w_next_state == S_EMIT);
            r_done  <= (w_next_state == S_DONE);

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_hi    <= i_hi;
                        r_count <= '0;
`ifdef PRIME_SWEEP_MAP_EN
                        r_map   <= '0;
`endif
                        if (i_lo <= i_hi) begin
                            r_cand <= i_lo;
                        end
                    end
                end
                S_SCAN: begin
                    if (i_is_prime) begin
                        // cand is frozen during EMIT. The same cand is then
                        // used for the post-transfer step.
                        r_prime_data  <= r_cand;
                        r_prime_valid <= 1'b1;
                        if (!w_count_max) begin
                            r_count <= r_count + 1'b1;
                        end
`ifdef PRIME_SWEEP_MAP_EN
                        r_map[r_cand] <= 1'b1;
`endif
                    end else if (!w_last) begin
                        r_cand <= r_cand + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_xfer) begin
                        r_prime_valid <= 1'b0;
                        if (!w_last) begin
                            r_cand <= r_cand + 1'b1;
                        end
                    end
                end
                default: begin
                    r_prime_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cand        = r_cand;
    assign o_prime_valid = r_prime_valid;
    assign o_prime_data  = r_prime_data;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_prime_count = r_count;
    assign o_state       = r_state;
`ifdef PRIME_SWEEP_MAP_EN
    assign o_prime_map   = r_map;
`endif

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
module tb_prime_sweep_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 5;
  localparam logic [1:0] S_IDLE = 2'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [WIDTH-1:0] lo = '0;
  logic [WIDTH-1:0] hi = '0;
  logic             ready = 1'b1;
  logic             is_prime;
  logic [WIDTH-1:0] cand;
  logic             prime_valid;
  logic [WIDTH-1:0] prime_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] prime_count;
  logic [1:0]       state;
`ifdef PRIME_SWEEP_MAP_EN
  logic [(2**WIDTH)-1:0] prime_map;
`endif

  prime_sweep_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_lo          (lo),
    .i_hi          (hi),
    .o_cand        (cand),
    .i_is_prime    (is_prime),
    .o_prime_valid (prime_valid),
    .o_prime_data  (prime_data),
    .i_prime_ready (ready),
    .o_busy        (busy),
    .o_done        (done),
    .o_prime_count (prime_count),
`ifdef PRIME_SWEEP_MAP_EN
    .o_prime_map   (prime_map),
`endif
    .o_state       (state)
  );

  // Combinational detector stand-in, answering for the current cand.
  function automatic logic prime_f(input logic [WIDTH-1:0] n);
    if (n < 2) return 1'b0;
    for (int d = 2; d < int'(n); d++) begin
      if ((int'(n) % d) == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  always_comb is_prime = prime_f(cand);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pops one expected prime.
  always @(negedge clk) begin
    if (!rst && prime_valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_prime", 32'(prime_data), 32'hFFFF_FFFF);
      end else begin
        check("stream_data", 32'(prime_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_sweep(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h);
    @(posedge clk); #1;
    lo = l;
    hi = h;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts busy cycles until done. It can also inject a start at a chosen
  // cycle, and that start must be ignored.
  task automatic run_to_done(output int busy_cyc, input int inj_cycle);
    bit seen;
    seen = 1'b0;
    busy_cyc = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == inj_cycle) begin
        start = 1'b1;
        lo = 4'd8;
        hi = 4'd9;
      end
      if (c == inj_cycle + 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (prime_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int bc;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(prime_valid), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_count", 32'(prime_count), 32'd0);
    check("rst_cand",  32'(cand),        32'd0);
    check("rst_data",  32'(prime_data),  32'd0);
    check("rst_state", 32'(state),       32'(S_IDLE));
`ifdef PRIME_SWEEP_MAP_EN
    check("rst_map",   32'(prime_map),   32'd0);
`endif

    // Full range, ready high. A start injected mid-sweep is ignored.
    exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd5);
    exp_q.push_back(4'd7); exp_q.push_back(4'd11); exp_q.push_back(4'd13);
    start_sweep(4'd0, 4'd15);
    run_to_done(bc, 5);
    check("full_busy_cycles", 32'(bc), 32'd22);
    check("full_done",  32'(done),        32'd1);
    check("full_count", 32'(prime_count), 32'd6);
    check("full_cand_no_wrap", 32'(cand), 32'd15);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef PRIME_SWEEP_MAP_EN
    check("full_map", 32'(prime_map), 32'h28AC);
`endif

    // No primes in range.
    start_sweep(4'd8, 4'd10);
    run_to_done(bc, -10);
    check("np_busy_cycles", 32'(bc), 32'd3);
    check("np_done",  32'(done),        32'd1);
    check("np_count", 32'(prime_count), 32'd0);
`ifdef PRIME_SWEEP_MAP_EN
    check("np_map_cleared", 32'(prime_map), 32'd0);
`endif

    // lo > hi: straight to DONE.
    start_sweep(4'd5, 4'd3);
    @(negedge clk);
    check("empty_done",  32'(done),        32'd1);
    check("empty_busy",  32'(busy),        32'd0);
    check("empty_count", 32'(prime_count), 32'd0);
    bc = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("empty_busy_never", 32'(bc), 32'd0);

    // Back-pressure at the first prime.
    @(posedge clk); #1 ready = 1'b0;
    exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    start_sweep(4'd0, 4'd3);
    wait_valid("stall_valid_seen");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_valid", 32'(prime_valid), 32'd1);
      check("stall_data",  32'(prime_data),  32'd2);
      check("stall_cand",  32'(cand),        32'd2);
    end
    @(posedge clk); #1 ready = 1'b1;
    run_to_done(bc, -10);
    check("stall_count", 32'(prime_count), 32'd2);
    check("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset while holding a prime in EMIT.
    @(posedge clk); #1 ready = 1'b0;
    start_sweep(4'd4, 4'd9);
    wait_valid("emit_valid_seen");
    check("emit_data", 32'(prime_data), 32'd5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", 32'(prime_valid), 32'd0);
    check("mrst_busy",  32'(busy),        32'd0);
    check("mrst_done",  32'(done),        32'd0);
    check("mrst_count", 32'(prime_count), 32'd0);
    check("mrst_state", 32'(state),       32'(S_IDLE));
    @(posedge clk); #1 ready = 1'b1;

    // Top of range: ends at 15 without wrapping.
    exp_q.push_back(4'd13);
    start_sweep(4'd13, 4'd15);
    run_to_done(bc, -10);
    check("top_busy_cycles", 32'(bc), 32'd4);
    check("top_count", 32'(prime_count), 32'd1);
    check("top_cand",  32'(cand),        32'd15);
    repeat (3) @(negedge clk);
    check("top_q_empty", 32'(exp_q.size()), 32'd0);
    check("top_done_held", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
